// File: rtl/redmule_tcdm_arbiter.sv
// Four-way TCDM arbiter for the RedMulE streamers: Z-urgency, round-robin, grant lock, in-order read routing.
// Optional macro REDMULE_ARB_STARVE_EN adds the Z-starvation counter and forced non-Z grant.
module redmule_tcdm_arbiter #(
  parameter int unsigned DATA_W     = 288,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STRB       = DATA_W / 8,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned MAX_OUTST  = 4,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic                               clk_i,
  input  logic                               clear_i,
  input  logic [N_REQ-1:0]                   req_i,
  output logic [N_REQ-1:0]                   gnt_o,
  input  logic [N_REQ-1:0]                   wen_i,
  input  logic [N_REQ-1:0][ADDR_W-1:0]       add_i,
  input  logic [N_REQ-1:0][DATA_W-1:0]       data_i,
  input  logic [N_REQ-1:0][STRB-1:0]         be_i,
  output logic [N_REQ-1:0]                   r_valid_o,
  output logic [DATA_W-1:0]                  r_data_o,
  input  logic                               z_urgent_i,
  output logic                               tcdm_req_o,
  input  logic                               tcdm_gnt_i,
  output logic                               tcdm_wen_o,
  output logic [ADDR_W-1:0]                  tcdm_add_o,
  output logic [DATA_W-1:0]                  tcdm_data_o,
  output logic [STRB-1:0]                    tcdm_be_o,
  input  logic                               tcdm_r_valid_i,
  input  logic [DATA_W-1:0]                  tcdm_r_data_i,
  output logic [$clog2(MAX_OUTST):0]         outst_o,
  output logic                               err_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned PTR_W = $clog2(MAX_OUTST);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [N_REQ-1:0] NONZ_MASK = {1'b0, {(N_REQ-1){1'b1}}};

  if (MAX_OUTST != (1 << PTR_W) || MAX_OUTST < 2 || STARVE_LIM == 0) begin : g_bad_param
    $error("redmule_tcdm_arbiter: MAX_OUTST must be a power of 2 >= 2 and STARVE_LIM nonzero");
  end

  logic             lock_q, lock_urg_q, err_q;
  logic [IDX_W-1:0] lock_idx_q, rr_ptr_q;
  logic [IDX_W-1:0] id_mem [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic             fifo_full, fifo_empty, force_rr;
  logic [N_REQ-1:0] elig, rr_cand;
  logic             sel_vld, sel_urg, hs, push, pop, bad_rsp;
  logic [IDX_W-1:0] sel;
  int unsigned      j;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTST));
  // Reads need a free ID slot; a same-cycle pop deliberately does not count.
  assign elig       = req_i & ~(wen_i & {N_REQ{fifo_full}});

`ifdef REDMULE_ARB_STARVE_EN
  localparam int unsigned SC_W = $clog2(STARVE_LIM + 1);
  logic [SC_W-1:0] starve_cnt_q;
  assign force_rr = (starve_cnt_q >= SC_W'(STARVE_LIM)) && (|(elig & NONZ_MASK));
`else
  assign force_rr = 1'b0;
`endif

  assign rr_cand = force_rr ? (elig & NONZ_MASK) : elig;

  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    sel_urg = 1'b0;
    j       = 0;
    if (lock_q) begin
      sel     = lock_idx_q;
      sel_vld = 1'b1;
      sel_urg = lock_urg_q;
    end else if (z_urgent_i && elig[N_REQ-1] && !force_rr) begin
      sel     = IDX_W'(N_REQ - 1);
      sel_vld = 1'b1;
      sel_urg = 1'b1;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        j = (32'(rr_ptr_q) + i) % N_REQ;
        if (!sel_vld && rr_cand[j]) begin
          sel     = IDX_W'(j);
          sel_vld = 1'b1;
        end
      end
    end
  end

  assign tcdm_req_o  = sel_vld & ~clear_i;
  assign tcdm_wen_o  = wen_i[sel];
  assign tcdm_add_o  = add_i[sel];
  assign tcdm_data_o = data_i[sel];
  assign tcdm_be_o   = be_i[sel];
  assign hs          = tcdm_req_o & tcdm_gnt_i;
  assign push        = hs & tcdm_wen_o;
  assign pop         = tcdm_r_valid_i & ~fifo_empty & ~clear_i;
  assign bad_rsp     = tcdm_r_valid_i & fifo_empty;

  always_comb begin
    gnt_o = '0;
    if (hs) gnt_o[sel] = 1'b1;
  end

  always_comb begin
    r_valid_o = '0;
    if (pop) r_valid_o[id_mem[rd_ptr_q]] = 1'b1;
  end

  assign r_data_o = tcdm_r_data_i;
  assign outst_o  = cnt_q;
  assign err_o    = err_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      lock_q     <= 1'b0;
      lock_urg_q <= 1'b0;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      if (tcdm_req_o && !tcdm_gnt_i) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
        lock_urg_q <= sel_urg;
      end else if (hs) begin
        lock_q <= 1'b0;
      end
      // Urgent Z grants leave the round-robin position untouched.
      if (hs && !sel_urg) rr_ptr_q <= IDX_W'((32'(sel) + 32'd1) % N_REQ);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
      if (bad_rsp) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_ptr_q] <= sel;
  end

`ifdef REDMULE_ARB_STARVE_EN
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      starve_cnt_q <= '0;
    end else if (!(|(elig & NONZ_MASK))) begin
      starve_cnt_q <= '0;
    end else if (hs && sel_urg) begin
      if (starve_cnt_q < SC_W'(STARVE_LIM)) starve_cnt_q <= starve_cnt_q + SC_W'(1);
    end else if (hs) begin
      starve_cnt_q <= '0;
    end
  end
`endif

  lock_keeps_req: assert property (@(posedge clk_i) disable iff (clear_i) lock_q |-> req_i[lock_idx_q]);

endmodule
